// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, constants and helpers for the uart_tx arbiter
package uart_arb_pkg;

  localparam int DW = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    LAUNCH    = ST_LAUNCH,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } state_e;

  // Index width for n requesters; never below 1 so ports stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector starting after last
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int            cand_int;
  logic [IW-1:0] cand;

  // Offsets 1..NREQ so that last itself is searched at the very end.
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand_int = 0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_int = (int'(last) + k) % NREQ;
      cand     = cand_int[IW-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx among NREQ byte producers
// Optional message lock via `UART_TX_ARBITER_LOCK_EN (adds lock[NREQ-1:0] input).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  localparam int IW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] data,
`ifdef UART_TX_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   ack,
  output logic              tx_start,
  output logic [DW-1:0]     tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic [IW-1:0]     grant_id
);

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            grant_ok;
  logic [IW-1:0]   win;
  logic [DW-1:0]   sel_byte;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .last  (grant_id_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef UART_TX_ARBITER_LOCK_EN
  // lock_vld_q marks that grant_id_q names a real grant, so a lock bit
  // seen right after reset cannot pin the bus to the reset value of grant_id.
  logic lock_vld_q, lock_vld_d;
  logic locked;

  assign locked = lock_vld_q && lock[grant_id_q];

  always_comb begin
    grant_ok = pick_valid;
    win      = pick_idx;
    if (locked) begin
      grant_ok = req[grant_id_q];
      win      = grant_id_q;
    end
  end

  always_comb begin
    lock_vld_d = lock_vld_q;
    if (state_q == IDLE && tx_ready && grant_ok) lock_vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) lock_vld_q <= 1'b0;
    else     lock_vld_q <= lock_vld_d;
  end
`else
  assign grant_ok = pick_valid;
  assign win      = pick_idx;
`endif

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) sel_byte = data[i*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ack_d      = '0;
    case (state_q)
      IDLE: begin
        // A low ready here means a foreign or leftover frame is still on the wire.
        if (tx_ready && grant_ok) begin
          grant_id_d = win;
          tx_data_d  = sel_byte;
          tx_start_d = 1'b1;
          ack_d[win] = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_ready)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= IW'(NREQ - 1);
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule
